// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: clock time and user controls in, alarm time and light-stage requests out.
interface alarm_trigger_if;
  logic [7:0] show_hour;
  logic [7:0] show_min;
  logic [7:0] show_sec;
  logic       alarm_en;
  logic       chime_en;
  logic       set_alarm;
  logic       inc_hour;
  logic       inc_min;
  logic       snooze;
  logic       dismiss;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       start_light_hour;
  logic       start_light_alarm;
  logic       active_alarm;
  logic [1:0] alarm_state;

  // Master side drives the clock time and buttons and observes the alarm outputs
  modport master (
    output show_hour, show_min, show_sec, alarm_en, chime_en, set_alarm,
           inc_hour, inc_min, snooze, dismiss,
    input  alarm_hour, alarm_min, start_light_hour, start_light_alarm,
           active_alarm, alarm_state
  );

  // Slave side is the alarm trigger itself
  modport slave (
    input  show_hour, show_min, show_sec, alarm_en, chime_en, set_alarm,
           inc_hour, inc_min, snooze, dismiss,
    output alarm_hour, alarm_min, start_light_hour, start_light_alarm,
           active_alarm, alarm_state
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm/chime event generator: stores a BCD alarm time, compares it against the running
// clock and sequences IDLE/ARMED/RINGING/SNOOZE, plus the hourly chime request.
module alarm_trigger #(
  parameter int unsigned RING_SECONDS     = 60,
  parameter int unsigned SNOOZE_SECONDS   = 300,
  parameter int unsigned MAX_SNOOZE       = 3,
  parameter logic [7:0]  ALARM_RESET_HOUR = 8'h07,
  parameter logic [7:0]  ALARM_RESET_MIN  = 8'h00
) (
  input logic            CP_1Hz,
  input logic            CR,
  alarm_trigger_if.slave bus
);

  localparam logic [15:0] RING_RELOAD   = 16'(RING_SECONDS - 1);
  localparam logic [15:0] SNOOZE_RELOAD = 16'(SNOOZE_SECONDS - 1);
  localparam logic [3:0]  SNOOZE_LIMIT  = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] ring_cnt, ring_cnt_next;
  logic [15:0] snooze_cnt, snooze_cnt_next;
  logic [3:0]  snooze_num, snooze_num_next;
  logic        enter_ring;
  logic [7:0]  alarm_hour, alarm_min;
  logic        inc_hour_prev, inc_min_prev, snooze_prev, dismiss_prev;
  logic        rise_inc_hour, rise_inc_min, rise_snooze, rise_dismiss;
  logic        start_light_alarm, active_alarm;
  logic        match;

  // BCD hour increment wrapping 23 -> 00
  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD minute increment wrapping 59 -> 00 with no carry out
  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign rise_inc_hour = bus.inc_hour & ~inc_hour_prev;
  assign rise_inc_min  = bus.inc_min  & ~inc_min_prev;
  assign rise_snooze   = bus.snooze   & ~snooze_prev;
  assign rise_dismiss  = bus.dismiss  & ~dismiss_prev;

  // Matching is suppressed while the user is editing the alarm time
  assign match = (bus.show_hour == alarm_hour) & (bus.show_min == alarm_min) &
                 (bus.show_sec == 8'h00) & ~bus.set_alarm;

  // Next-state logic; counters and snooze count move only with their transitions
  always_comb begin
    state_next      = state;
    ring_cnt_next   = ring_cnt;
    snooze_cnt_next = snooze_cnt;
    snooze_num_next = snooze_num;
    enter_ring      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.alarm_en) state_next = ARMED;
      end
      ARMED: begin
        if (!bus.alarm_en) begin
          state_next = IDLE;
        end else if (match) begin
          state_next      = RINGING;
          ring_cnt_next   = RING_RELOAD;
          snooze_num_next = 4'd0;
          enter_ring      = 1'b1;
        end
      end
      RINGING: begin
        if (!bus.alarm_en) begin
          state_next = IDLE;
        end else if (rise_dismiss) begin
          state_next = ARMED;
        end else if (rise_snooze) begin
          if (snooze_num < SNOOZE_LIMIT) begin
            state_next      = SNOOZE;
            snooze_cnt_next = SNOOZE_RELOAD;
            snooze_num_next = snooze_num + 4'd1;
          end else begin
            state_next = ARMED;
          end
        end else if (ring_cnt == 16'd0) begin
          state_next = ARMED;
        end else begin
          ring_cnt_next = ring_cnt - 16'd1;
        end
      end
      SNOOZE: begin
        if (!bus.alarm_en) begin
          state_next = IDLE;
        end else if (rise_dismiss) begin
          state_next = ARMED;
        end else if (snooze_cnt == 16'd0) begin
          state_next    = RINGING;
          ring_cnt_next = RING_RELOAD;
          enter_ring    = 1'b1;
        end else begin
          snooze_cnt_next = snooze_cnt - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, alarm time, button history and registered light requests
  always_ff @(posedge CP_1Hz) begin
    if (CR) begin
      state             <= IDLE;
      ring_cnt          <= 16'd0;
      snooze_cnt        <= 16'd0;
      snooze_num        <= 4'd0;
      alarm_hour        <= ALARM_RESET_HOUR;
      alarm_min         <= ALARM_RESET_MIN;
      inc_hour_prev     <= 1'b0;
      inc_min_prev      <= 1'b0;
      snooze_prev       <= 1'b0;
      dismiss_prev      <= 1'b0;
      start_light_alarm <= 1'b0;
      active_alarm      <= 1'b0;
    end else begin
      state             <= state_next;
      ring_cnt          <= ring_cnt_next;
      snooze_cnt        <= snooze_cnt_next;
      snooze_num        <= snooze_num_next;
      inc_hour_prev     <= bus.inc_hour;
      inc_min_prev      <= bus.inc_min;
      snooze_prev       <= bus.snooze;
      dismiss_prev      <= bus.dismiss;
      start_light_alarm <= enter_ring;
      active_alarm      <= (state_next == RINGING);
      if (bus.set_alarm && rise_inc_hour) alarm_hour <= bcd_inc_hour(alarm_hour);
      if (bus.set_alarm && rise_inc_min)  alarm_min  <= bcd_inc_min(alarm_min);
    end
  end

  assign bus.alarm_hour        = alarm_hour;
  assign bus.alarm_min         = alarm_min;
  assign bus.alarm_state       = state;
  assign bus.start_light_alarm = start_light_alarm;
  assign bus.active_alarm      = active_alarm;
  assign bus.start_light_hour  = bus.chime_en & (bus.show_min == 8'h00);

endmodule
